operand_fetch_unit: RTL and testbench



---
 rtl/operand_fetch_unit_pkg.sv | 22 ++
 rtl/operand_fetch_unit_if.sv | 30 +++
 rtl/operand_fetch_unit_group_reg.sv | 58 +++++
 rtl/operand_fetch_unit.sv | 197 +++++++++++++++++++
 tb/tb_operand_fetch_unit.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared types for the operand fetch unit: beat layout, FSM states, beat width.
package bitfuscnn_pkg;

  localparam int unsigned OFU_DATA_W  = 8;
  localparam int unsigned OFU_INDEX_W = 16;
  localparam int unsigned BEAT_W      = 2 * (OFU_DATA_W + OFU_INDEX_W);

  // Field order mirrors the RAM word: weight sits at the LSB end.
  typedef struct packed {
    logic [OFU_INDEX_W-1:0] act_index;
    logic [OFU_DATA_W-1:0]  act;
    logic [OFU_INDEX_W-1:0] w_index;
    logic [OFU_DATA_W-1:0]  w;
  } operand_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ofu_state_e;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Beat-in / group-out handshake bundle of the operand fetch unit.
interface operand_fetch_unit_if #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INDEX_W = 16
);
  logic                          beat_valid;
  logic                          beat_ready;
  logic [2*(DATA_W+INDEX_W)-1:0] beat_data;
  logic                          grp_valid;
  logic                          grp_ready;
  logic [LANES*DATA_W-1:0]       grp_weight;
  logic [LANES*DATA_W-1:0]       grp_activation;
  logic [LANES*INDEX_W-1:0]      grp_weight_index;
  logic [LANES*INDEX_W-1:0]      grp_activation_index;
  logic [LANES-1:0]              grp_lane_mask;
  logic                          grp_last;

  modport master (
    output beat_valid, beat_data, grp_ready,
    input  beat_ready, grp_valid, grp_weight, grp_activation,
           grp_weight_index, grp_activation_index, grp_lane_mask, grp_last
  );

  modport slave (
    input  beat_valid, beat_data, grp_ready,
    output beat_ready, grp_valid, grp_weight, grp_activation,
           grp_weight_index, grp_activation_index, grp_lane_mask, grp_last
  );
endinterface

// File: rtl/operand_fetch_unit_group_reg.sv
// Output holding register for one operand group plus lane-mask/last sideband.
module operand_group_reg #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INDEX_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     load,
  input  logic [LANES*DATA_W-1:0]  ld_weight,
  input  logic [LANES*DATA_W-1:0]  ld_activation,
  input  logic [LANES*INDEX_W-1:0] ld_weight_index,
  input  logic [LANES*INDEX_W-1:0] ld_activation_index,
  input  logic [LANES-1:0]         ld_lane_mask,
  input  logic                     ld_last,
  output logic                     grp_valid,
  input  logic                     grp_ready,
  output logic [LANES*DATA_W-1:0]  grp_weight,
  output logic [LANES*DATA_W-1:0]  grp_activation,
  output logic [LANES*INDEX_W-1:0] grp_weight_index,
  output logic [LANES*INDEX_W-1:0] grp_activation_index,
  output logic [LANES-1:0]         grp_lane_mask,
  output logic                     grp_last
);

  // load is only asserted by the parent when the register is free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grp_valid            <= 1'b0;
      grp_weight           <= '0;
      grp_activation       <= '0;
      grp_weight_index     <= '0;
      grp_activation_index <= '0;
      grp_lane_mask        <= '0;
      grp_last             <= 1'b0;
    end else if (clear) begin
      grp_valid            <= 1'b0;
      grp_weight           <= '0;
      grp_activation       <= '0;
      grp_weight_index     <= '0;
      grp_activation_index <= '0;
      grp_lane_mask        <= '0;
      grp_last             <= 1'b0;
    end else if (load) begin
      grp_valid            <= 1'b1;
      grp_weight           <= ld_weight;
      grp_activation       <= ld_activation;
      grp_weight_index     <= ld_weight_index;
      grp_activation_index <= ld_activation_index;
      grp_lane_mask        <= ld_lane_mask;
      grp_last             <= ld_last;
    end else if (grp_ready) begin
      grp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Packs serial operand beats into LANES-wide groups with valid/ready back-pressure.
// Optional macro OPERAND_ZERO_SKIP_EN: drop beats whose weight or activation is zero.
module operand_fetch_unit
  import bitfuscnn_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INDEX_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [CNT_W-1:0] num_beats,
  operand_fetch_unit_if.slave bus,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FC_W = $clog2(LANES) + 1;

  ofu_state_e state_q, state_d;

  logic [CNT_W-1:0]         num_q, beat_cnt;
  logic [CNT_W:0]           beat_inc;
  logic [FC_W-1:0]          fill_cnt, fill_inc;
  logic [LANES*DATA_W-1:0]  fill_w, fill_a, nf_w, nf_a;
  logic [LANES*INDEX_W-1:0] fill_wi, fill_ai, nf_wi, nf_ai;
  logic [LANES-1:0]         fill_mask, nf_mask;
  logic                     closed, fill_last, done_q;
  logic                     accept, is_final, store, close_now, out_free, load, ld_last, last_hs;
  logic [DATA_W-1:0]        b_w, b_a;
  logic [INDEX_W-1:0]       b_wi, b_ai;

  assign b_w  = bus.beat_data[0 +: DATA_W];
  assign b_wi = bus.beat_data[DATA_W +: INDEX_W];
  assign b_a  = bus.beat_data[DATA_W+INDEX_W +: DATA_W];
  assign b_ai = bus.beat_data[2*DATA_W+INDEX_W +: INDEX_W];

  // closed: fill buffer holds a finished group waiting for the output register.
  assign bus.beat_ready = (state_q == RUN) && !closed &&
                          (fill_cnt < FC_W'(LANES)) && (beat_cnt < num_q);
  assign accept   = bus.beat_valid && bus.beat_ready;
  assign beat_inc = {1'b0, beat_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign is_final = (beat_inc == {1'b0, num_q});

`ifdef OPERAND_ZERO_SKIP_EN
  assign store = (b_w != '0) && (b_a != '0);
`else
  assign store = 1'b1;
`endif

  assign fill_inc  = fill_cnt + {{(FC_W-1){1'b0}}, store};
  assign close_now = accept && ((fill_inc == FC_W'(LANES)) || is_final);
  assign out_free  = !bus.grp_valid || bus.grp_ready;
  assign load      = out_free && (closed || close_now);
  assign ld_last   = closed ? fill_last : is_final;
  assign last_hs   = bus.grp_valid && bus.grp_ready && bus.grp_last;

  // Fill buffer with the incoming beat merged into its lane.
  always_comb begin
    nf_w    = fill_w;
    nf_a    = fill_a;
    nf_wi   = fill_wi;
    nf_ai   = fill_ai;
    nf_mask = fill_mask;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (accept && store && (fill_cnt == FC_W'(i))) begin
        nf_w[i*DATA_W +: DATA_W]   = b_w;
        nf_a[i*DATA_W +: DATA_W]   = b_a;
        nf_wi[i*INDEX_W +: INDEX_W] = b_wi;
        nf_ai[i*INDEX_W +: INDEX_W] = b_ai;
        nf_mask[i]                  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (num_beats != '0)) state_d = RUN;
      RUN:     if (accept && is_final)         state_d = DRAIN;
      DRAIN:   if (last_hs)                    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q     <= '0;
      beat_cnt  <= '0;
      fill_cnt  <= '0;
      fill_w    <= '0;
      fill_a    <= '0;
      fill_wi   <= '0;
      fill_ai   <= '0;
      fill_mask <= '0;
      closed    <= 1'b0;
      fill_last <= 1'b0;
      done_q    <= 1'b0;
    end else if (flush) begin
      num_q     <= '0;
      beat_cnt  <= '0;
      fill_cnt  <= '0;
      fill_w    <= '0;
      fill_a    <= '0;
      fill_wi   <= '0;
      fill_ai   <= '0;
      fill_mask <= '0;
      closed    <= 1'b0;
      fill_last <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= ((state_q == IDLE) && start && (num_beats == '0)) ||
                ((state_q == DRAIN) && last_hs);
      if ((state_q == IDLE) && start) begin
        num_q     <= num_beats;
        beat_cnt  <= '0;
        fill_cnt  <= '0;
        fill_w    <= '0;
        fill_a    <= '0;
        fill_wi   <= '0;
        fill_ai   <= '0;
        fill_mask <= '0;
        closed    <= 1'b0;
        fill_last <= 1'b0;
      end else if (accept) begin
        beat_cnt <= beat_inc[CNT_W-1:0];
        if (close_now && out_free) begin
          fill_cnt  <= '0;
          fill_w    <= '0;
          fill_a    <= '0;
          fill_wi   <= '0;
          fill_ai   <= '0;
          fill_mask <= '0;
        end else begin
          fill_cnt  <= fill_inc;
          fill_w    <= nf_w;
          fill_a    <= nf_a;
          fill_wi   <= nf_wi;
          fill_ai   <= nf_ai;
          fill_mask <= nf_mask;
          if (close_now) begin
            closed    <= 1'b1;
            fill_last <= is_final;
          end
        end
      end else if (closed && out_free) begin
        fill_cnt  <= '0;
        fill_w    <= '0;
        fill_a    <= '0;
        fill_wi   <= '0;
        fill_ai   <= '0;
        fill_mask <= '0;
        closed    <= 1'b0;
        fill_last <= 1'b0;
      end
    end
  end

  // While a closed group waits, no beat is accepted, so nf_* equals the fill buffer.
  operand_group_reg #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W)
  ) u_group_reg (
    .clk                 (clk),
    .reset_n             (reset_n),
    .clear               (flush),
    .load                (load),
    .ld_weight           (nf_w),
    .ld_activation       (nf_a),
    .ld_weight_index     (nf_wi),
    .ld_activation_index (nf_ai),
    .ld_lane_mask        (nf_mask),
    .ld_last             (ld_last),
    .grp_valid           (bus.grp_valid),
    .grp_ready           (bus.grp_ready),
    .grp_weight          (bus.grp_weight),
    .grp_activation      (bus.grp_activation),
    .grp_weight_index    (bus.grp_weight_index),
    .grp_activation_index(bus.grp_activation_index),
    .grp_lane_mask       (bus.grp_lane_mask),
    .grp_last            (bus.grp_last)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized bench for operand_fetch_unit against a list-based grouping model.
module tb_operand_fetch_unit;
  import bitfuscnn_pkg::*;

  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INDEX_W = 16;
  localparam int unsigned CNT_W   = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] num_beats = '0;
  logic             busy, done;

  operand_fetch_unit_if #(.LANES(LANES), .DATA_W(DATA_W), .INDEX_W(INDEX_W)) bus ();

  operand_fetch_unit #(
    .LANES(LANES), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .num_beats(num_beats), .bus(bus.slave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DATA_W-1:0]  w;
    logic [LANES*DATA_W-1:0]  a;
    logic [LANES*INDEX_W-1:0] wi;
    logic [LANES*INDEX_W-1:0] ai;
    logic [LANES-1:0]         mask;
    logic                     last;
  } grp_t;

  operand_beat_t           tile[$];
  grp_t                    exp_q[$];
  logic [LANES*DATA_W-1:0] got_w[$];
  logic [LANES-1:0]        got_m[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit kept(input operand_beat_t b);
`ifdef OPERAND_ZERO_SKIP_EN
    return (b.w != '0) && (b.act != '0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic operand_beat_t rand_beat(input bit allow_zero);
    operand_beat_t b;
    b.w         = DATA_W'($urandom);
    b.act       = DATA_W'($urandom);
    b.w_index   = INDEX_W'($urandom);
    b.act_index = INDEX_W'($urandom);
    if (allow_zero) begin
      if ($urandom_range(0, 3) == 0) b.w = '0;
      if ($urandom_range(0, 3) == 0) b.act = '0;
    end else begin
      if (b.w == '0)   b.w = 1;
      if (b.act == '0) b.act = 1;
    end
    return b;
  endfunction

  // Chop the kept beats into LANES-sized groups; the final beat always closes one.
  task automatic build_expected();
    grp_t g;
    int   cnt;
    exp_q.delete();
    g   = '{default: '0};
    cnt = 0;
    for (int i = 0; i < tile.size(); i++) begin
      if (kept(tile[i])) begin
        g.w[cnt*DATA_W +: DATA_W]    = tile[i].w;
        g.a[cnt*DATA_W +: DATA_W]    = tile[i].act;
        g.wi[cnt*INDEX_W +: INDEX_W] = tile[i].w_index;
        g.ai[cnt*INDEX_W +: INDEX_W] = tile[i].act_index;
        g.mask[cnt]                  = 1'b1;
        cnt++;
      end
      if (cnt == LANES || i == tile.size() - 1) begin
        g.last = (i == tile.size() - 1);
        exp_q.push_back(g);
        g   = '{default: '0};
        cnt = 0;
      end
    end
  endtask

  task automatic run_tile(input int vprob, input int rprob, input int stall_len);
    int n, idx, hs, stall_cnt, lim;
    bit stall_on, expect_done, finished, prev_hold;
    logic [LANES*DATA_W-1:0] prev_w;
    grp_t e;
    n = tile.size(); idx = 0; hs = 0; stall_cnt = 0; lim = 0;
    stall_on = 0; expect_done = 0; finished = 0; prev_hold = 0; prev_w = '0;
    build_expected();
    got_w.delete(); got_m.delete();
    start = 1'b1; num_beats = CNT_W'(n); bus.beat_valid = 1'b0; bus.grp_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      bus.beat_valid = (idx < n) && ($urandom_range(0, 99) < vprob);
      bus.beat_data  = (idx < n) ? tile[idx] : '0;
      if (stall_on && stall_cnt < stall_len) bus.grp_ready = 1'b0;
      else bus.grp_ready = ($urandom_range(0, 99) < rprob);
      @(negedge clk);
      if (cyc == 0) check_eq("busy_run", busy, 1);
      if (prev_hold) begin
        check_eq("hold_valid", bus.grp_valid, 1);
        check_eq("hold_weight", bus.grp_weight, prev_w);
      end
      if (expect_done) begin
        check_eq("done_pulse", done, 1);
        finished = 1;
      end else check_eq("done_quiet", done, 0);
      if (bus.beat_valid && bus.beat_ready) idx++;
      if (stall_on && !bus.grp_ready && stall_cnt < stall_len) begin
        stall_cnt++;
        if (stall_cnt == stall_len) begin
          // Output register plus fill buffer can absorb two groups beyond those taken.
          lim = (hs + 2) * LANES;
          if (lim > n) lim = n;
          check_eq("stall_accepted", idx, lim);
          if (n > lim) check_eq("stall_beat_ready", bus.beat_ready, 0);
        end
      end
      if (bus.grp_valid && bus.grp_ready) begin
        hs++;
        if (exp_q.size() == 0) check_eq("extra_group", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("grp_weight", bus.grp_weight, e.w);
          check_eq("grp_act", bus.grp_activation, e.a);
          check_eq("grp_w_index", bus.grp_weight_index, e.wi);
          check_eq("grp_a_index", bus.grp_activation_index, e.ai);
          check_eq("grp_mask", bus.grp_lane_mask, e.mask);
          check_eq("grp_last", bus.grp_last, e.last);
          if (e.last) expect_done = 1;
        end
        got_w.push_back(bus.grp_weight);
        got_m.push_back(bus.grp_lane_mask);
        if (stall_len > 0) stall_on = 1;
      end
      prev_hold = bus.grp_valid && !bus.grp_ready;
      prev_w    = bus.grp_weight;
      if (!finished) begin
        @(posedge clk); #1;
      end
    end
    if (!finished) check_eq("tile_timeout", 0, 1);
    check_eq("beats_accepted", idx, n);
    check_eq("groups_left", exp_q.size(), 0);
    check_eq("busy_after", busy, 0);
    bus.beat_valid = 1'b0;
    bus.grp_ready  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic seq_tile(input int n);
    operand_beat_t b;
    tile.delete();
    for (int i = 1; i <= n; i++) begin
      b.w = DATA_W'(i); b.act = DATA_W'(8'h10 + i);
      b.w_index = INDEX_W'(16'h0100 + i); b.act_index = INDEX_W'(16'h0200 + i);
      tile.push_back(b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [LANES*DATA_W-1:0] gw;
    logic [DATA_W-1:0]       lane0, first_w;
    int k, seen;
    operand_beat_t b;

    bus.beat_valid = 1'b0; bus.beat_data = '0; bus.grp_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_grp_valid", bus.grp_valid, 0);
    check_eq("rst_beat_ready", bus.beat_ready, 0);
    check_eq("rst_mask", bus.grp_lane_mask, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full tile of 8
    seq_tile(8);
    run_tile(100, 100, 0);
    check_eq("t8_groups", got_w.size(), 2);
    if (got_w.size() == 2) begin
      check_eq("t8_w0", got_w[0], 32'h04030201);
      check_eq("t8_w1", got_w[1], 32'h08070605);
      check_eq("t8_m0", got_m[0], 4'hF);
      check_eq("t8_m1", got_m[1], 4'hF);
    end

    // Partial final group
    seq_tile(6);
    run_tile(100, 100, 0);
    check_eq("t6_groups", got_w.size(), 2);
    if (got_w.size() == 2) begin
      check_eq("t6_w1", got_w[1], 32'h00000605);
      check_eq("t6_m1", got_m[1], 4'b0011);
    end

    // Long downstream stall after first group
    tile.delete();
    for (int i = 0; i < 16; i++) tile.push_back(rand_beat(0));
    run_tile(100, 100, 10);

    // Empty tile
    start = 1'b1; num_beats = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    check_eq("zero_grp_valid", bus.grp_valid, 0);
    @(negedge clk);
    check_eq("zero_done_clear", done, 0);
    check_eq("zero_grp_valid2", bus.grp_valid, 0);
    @(posedge clk); #1;

    // Reset mid-fill
    start = 1'b1; num_beats = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      b = rand_beat(0);
      bus.beat_valid = 1'b1; bus.beat_data = b; bus.grp_ready = 1'b1;
      @(negedge clk);
      if (bus.beat_valid && bus.beat_ready) k++;
      @(posedge clk); #1;
    end
    bus.beat_valid = 1'b0;
    check_eq("pre_reset_beats", k, 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_beat_ready", bus.beat_ready, 0);
    check_eq("mid_rst_grp_valid", bus.grp_valid, 0);
    check_eq("mid_rst_done", done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.grp_ready = 1'b0;
    @(posedge clk); #1;
    tile.delete();
    for (int i = 0; i < 4; i++) tile.push_back(rand_beat(0));
    first_w = tile[0].w;
    run_tile(100, 100, 0);
    check_eq("post_rst_groups", got_w.size(), 1);
    if (got_w.size() == 1) begin
      gw = got_w[0];
      lane0 = gw[DATA_W-1:0];
      check_eq("post_rst_lane0", lane0, first_w);
      check_eq("post_rst_mask", got_m[0], 4'hF);
    end

    // Flush while a group waits downstream
    start = 1'b1; num_beats = CNT_W'(10);
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      bus.beat_valid = 1'b1; bus.beat_data = rand_beat(0); bus.grp_ready = 1'b0;
      @(negedge clk);
      if (bus.grp_valid) seen = 1;
      @(posedge clk); #1;
    end
    check_eq("flush_grp_seen", seen, 1);
    bus.beat_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_busy", busy, 0);
    check_eq("flush_grp_valid", bus.grp_valid, 0);
    check_eq("flush_beat_ready", bus.beat_ready, 0);
    check_eq("flush_done", done, 0);
    @(negedge clk);
    check_eq("flush_done_late", done, 0);
    @(posedge clk); #1;

`ifdef OPERAND_ZERO_SKIP_EN
    seq_tile(5);
    tile[1].w = '0;
    tile[3].w = '0;
    run_tile(100, 100, 0);
    check_eq("zs_groups", got_w.size(), 1);
    if (got_w.size() == 1) begin
      check_eq("zs_w0", got_w[0], 32'h00050301);
      check_eq("zs_m0", got_m[0], 4'b0111);
    end
`endif

    // Random tiles
    for (int t = 0; t < 25; t++) begin
      tile.delete();
      k = $urandom_range(1, 20);
      for (int i = 0; i < k; i++) tile.push_back(rand_beat(1));
      run_tile($urandom_range(30, 100), $urandom_range(30, 100), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
